// File: rtl/bit4_signed_multiplier_pkg.sv
// Shared widths, product type and partial-product helpers for the 4x4 signed
// Baugh-Wooley multiplier.
package bit4_signed_multiplier_pkg;

    localparam int OPERAND_W = 4;
    localparam int RESULT_W  = 9;
    localparam int PP_W      = 2 * OPERAND_W;
    localparam int ADD_ROWS  = OPERAND_W - 1;

    typedef logic signed [RESULT_W-1:0] product_t;

    // Folds the -2^(i+3) terms of both sign rows into two constant ones (bits 4 and 7).
    localparam logic [PP_W-1:0] BW_CORRECTION = 8'b1001_0000;

    // One 4-bit partial-product row for multiplier bit b_bit. Ordinary rows invert
    // only the A[3] term; the B[3] row inverts the magnitude terms instead.
    function automatic logic [OPERAND_W-1:0] pp_row(
        input logic [OPERAND_W-1:0] a,
        input logic                 b_bit,
        input logic                 sign_row
    );
        logic [OPERAND_W-1:0] raw;
        raw = a & {OPERAND_W{b_bit}};
        if (sign_row) begin
            return {raw[OPERAND_W-1], ~raw[OPERAND_W-2:0]};
        end
        return {~raw[OPERAND_W-1], raw[OPERAND_W-2:0]};
    endfunction

    // The 8-bit array result already holds the full range -56..+64.
    function automatic product_t sext_product(input logic [PP_W-1:0] raw);
        return product_t'({raw[PP_W-1], raw});
    endfunction

endpackage

// File: rtl/bit4_signed_multiplier_full_adder.sv
// One-bit full adder used as the cell of the partial-product reduction array.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/bit4_signed_multiplier.sv
// 4x4 signed multiplier: Baugh-Wooley partial products, ripple adder array of
// full_adder cells, and a registered 9-bit result.
module bit4_signed_multiplier
    import bit4_signed_multiplier_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [OPERAND_W-1:0] A,
    input  logic [OPERAND_W-1:0] B,
    input  logic                 in_valid,
    output product_t             Out,
    output logic                 out_valid
);

    logic [PP_W-1:0]     base_row;
    logic [PP_W-1:0]     addend [ADD_ROWS];
    logic [PP_W-1:0]     product_raw;
    logic [ADD_ROWS-1:0] unused_msb_carry;

    // Row 0 carries the correction constant in its otherwise empty upper bits.
    always_comb begin
        base_row = BW_CORRECTION | PP_W'(pp_row(A, B[0], 1'b0));
        for (int r = 1; r <= ADD_ROWS; r++) begin
            addend[r-1] = PP_W'(pp_row(A, B[r], r == ADD_ROWS)) << r;
        end
    end

    genvar r, k;
    generate
        for (r = 0; r < ADD_ROWS; r++) begin : g_row
            logic [PP_W-1:0] acc_in;
            logic [PP_W-1:0] acc_out;

            if (r == 0) begin : g_first
                assign acc_in = base_row;
            end else begin : g_chain
                assign acc_in = g_row[r-1].acc_out;
            end

            for (k = 0; k < PP_W; k++) begin : g_bit
                logic cin;
                logic cout;

                if (k == 0) begin : g_lsb
                    assign cin = 1'b0;
                end else begin : g_ripple
                    assign cin = g_bit[k-1].cout;
                end

                full_adder u_fa (
                    .a    (acc_in[k]),
                    .b    (addend[r][k]),
                    .cin  (cin),
                    .sum  (acc_out[k]),
                    .cout (cout)
                );
            end

            // Sum is taken modulo 2^8; the top carry carries no information.
            assign unused_msb_carry[r] = g_bit[PP_W-1].cout;
        end
    endgenerate

    assign product_raw = g_row[ADD_ROWS-1].acc_out;

    // Valid-only handshake, no backpressure: a pair is accepted on every edge
    // with in_valid=1 and rst=0; out_valid pulses on the next cycle alongside its
    // product, and Out holds its last product while in_valid is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            Out       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                Out <= sext_product(product_raw);
            end
        end
    end

endmodule

// File: tb/tb_bit4_signed_multiplier.sv
// Self-checking bench for bit4_signed_multiplier: directed corner cases,
// streaming/hold, random traffic with resets, and an exhaustive commutative sweep.
module tb_bit4_signed_multiplier;

    logic       clk;
    logic       rst;
    logic [3:0] A;
    logic [3:0] B;
    logic       in_valid;
    logic [8:0] Out;
    logic       out_valid;

    int checks = 0;
    int errors = 0;

    logic [8:0] exp_q[$];
    logic [8:0] model_out;

    bit4_signed_multiplier dut (
        .clk       (clk),
        .rst       (rst),
        .A         (A),
        .B         (B),
        .in_valid  (in_valid),
        .Out       (Out),
        .out_valid (out_valid)
    );

    // Clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Reference: plain signed integer product, truncated to 9 bits
    function automatic logic [8:0] ref_product(input logic [3:0] a, input logic [3:0] b);
        int sa;
        int sb;
        int p;
        sa = int'($signed(a));
        sb = int'($signed(b));
        p  = sa * sb;
        return p[8:0];
    endfunction

    task automatic check9(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Driver + scoreboard: drive on negedge, check 1 ns after the sampling edge
    task automatic step(input logic [3:0] a, input logic [3:0] b, input logic v,
                        input logic r, input string tag);
        logic [8:0] exp;
        @(negedge clk);
        A        = a;
        B        = b;
        in_valid = v;
        rst      = r;
        if (r) begin
            exp_q.delete();
        end else if (v) begin
            exp_q.push_back(ref_product(a, b));
        end
        @(posedge clk);
        #1;
        if (r) begin
            model_out = 9'h000;
            check9({tag, "_rst_out"}, Out, 9'h000);
            check1({tag, "_rst_vld"}, out_valid, 1'b0);
        end else if (v) begin
            exp       = exp_q.pop_front();
            model_out = exp;
            check1({tag, "_vld"}, out_valid, 1'b1);
            check9({tag, "_out"}, Out, exp);
        end else begin
            check1({tag, "_idle_vld"}, out_valid, 1'b0);
            check9({tag, "_hold"}, Out, model_out);
        end
    endtask

    initial begin
        logic [3:0] ra;
        logic [3:0] rb;
        rst       = 1'b1;
        A         = 4'h0;
        B         = 4'h0;
        in_valid  = 1'b0;
        model_out = 9'h000;

        // Reset with a live operand pair: pair is discarded
        step(4'b0111, 4'b0111, 1'b1, 1'b1, "reset");
        step(4'b0111, 4'b0111, 1'b1, 1'b1, "reset2");
        // First valid cycle after reset produces on the next edge
        step(4'b0011, 4'b0110, 1'b1, 1'b0, "post_rst");
        check9("post_rst_const", Out, 9'h012);

        // Directed and extreme pairs streamed back to back
        step(4'b0111, 4'b1000, 1'b1, 1'b0, "ext_7xm8");
        check9("ext_7xm8_const", Out, 9'h1C8);
        step(4'b1000, 4'b0111, 1'b1, 1'b0, "ext_m8x7");
        check9("ext_m8x7_const", Out, 9'h1C8);
        step(4'b1000, 4'b1000, 1'b1, 1'b0, "ext_m8xm8");
        check9("ext_m8xm8_const", Out, 9'h040);
        step(4'b0000, 4'b1111, 1'b1, 1'b0, "dir_0xm1");
        check9("dir_0xm1_const", Out, 9'h000);
        step(4'b1010, 4'b1101, 1'b1, 1'b0, "dir_m6xm3");
        check9("dir_m6xm3_const", Out, 9'h012);
        step(4'b0011, 4'b0110, 1'b1, 1'b0, "dir_3x6");
        check9("dir_3x6_const", Out, 9'h012);

        // Hold: operands wiggle with in_valid low
        for (int i = 0; i < 6; i++) begin
            step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0, 1'b0, "hold");
            check9("hold_const", Out, 9'h012);
        end

        // Random traffic with sparse valid gaps and occasional resets
        for (int i = 0; i < 300; i++) begin
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            step(ra, rb, ($urandom_range(0, 3) != 0), ($urandom_range(0, 40) == 0), "rand");
        end

        // Exhaustive sweep, each pair followed by its swapped twin
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                step(4'(a), 4'(b), 1'b1, 1'b0, "exh_ab");
                step(4'(b), 4'(a), 1'b1, 1'b0, "exh_ba");
                check9("commute", Out, ref_product(4'(a), 4'(b)));
            end
        end

        step(4'h0, 4'h0, 1'b0, 1'b0, "tail");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bit4_signed_multiplier.md
BIT4_SIGNED_MULTIPLIER -- requirements
Module: bit4_signed_multiplier

Interface
REQ-001 The module SHALL have no parameters; operand widths are fixed at 4 bits and the result width at 9 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 A  input  4  multiplicand, two's-complement signed, range -8..+7.
REQ-005 B  input  4  multiplier, two's-complement signed, range -8..+7.
REQ-006 in_valid  input  1  A/B qualify this cycle; operands are captured when high.
REQ-007 Out  output  9  registered signed product A*B, two's complement.
REQ-008 out_valid  output  1  high for exactly one cycle when Out holds a newly computed product.

Function
REQ-009 The product SHALL be the exact signed value A*B, range -56..+64, sign-extended to 9 bits.
REQ-010 The full 4x4 signed product SHALL be computed combinationally in one cycle from A and B (Baugh-Wooley or sign-extended partial-product array); no multiply operator on signed types.
REQ-011 On a rising edge with rst=0 and in_valid=1, Out SHALL load the product of the A/B present at that edge, and out_valid SHALL be set to 1; latency is 1 cycle, throughput 1 product per cycle.
REQ-012 On a rising edge with rst=0 and in_valid=0, Out SHALL hold its previous value and out_valid SHALL be 0.
REQ-013 Back-to-back in_valid cycles SHALL each produce a result on the following cycle, with no bubbles and no backpressure.
REQ-014 Out SHALL never be X/undefined after the first reset edge; A/B changes while in_valid=0 SHALL NOT affect Out.
REQ-015 Boundary results: -8*-8 = +64 (9'h040, no overflow); 7*-8 and -8*7 = -56 (9'h1C8); 0*x = 0 for any x.
REQ-016 Multiplication SHALL be commutative at the output: Out(A,B) == Out(B,A) for all 256 operand pairs.

Reset
REQ-017 While rst=1 at a rising edge, Out SHALL be 9'h000 and out_valid SHALL be 0, regardless of in_valid.
REQ-018 rst SHALL take priority over in_valid; an operand pair presented in the same cycle as rst is discarded.
REQ-019 After rst deasserts, the first in_valid cycle SHALL produce its result on the next edge; no warm-up cycles.

Structure
REQ-020 A shared package SHALL define the constants OPERAND_W=4 and RESULT_W=9 and a signed 9-bit product type.
REQ-021 A single sub-module, full_adder (a, b, cin -> sum, cout), SHALL be instantiated to form the partial-product reduction array.
REQ-022 The partial-product generation (AND / NAND for sign rows), the adder array, and the output register SHALL be the only logic in the top module.

Verification
REQ-023 Reset: assert rst with in_valid=1, A=4'b0111, B=4'b0111 -> Out=9'h000, out_valid=0; deassert -> next valid product appears one cycle later.
REQ-024 Directed: A=0000, B=1111 -> 0 (9'h000); A=1010, B=1101 (-6*-3) -> +18 (9'h012); A=0011, B=0110 (3*6) -> +18 (9'h012).
REQ-025 Extremes: A=0111, B=1000 -> 9'h1C8; A=1000, B=0111 -> 9'h1C8; A=1000, B=1000 -> 9'h040.
REQ-026 Throughput/hold: stream the above six pairs on consecutive cycles with in_valid=1 -> six consecutive out_valid pulses with matching products, each one cycle after its input; then in_valid=0 with random A/B -> Out holds 9'h012, out_valid=0.
REQ-027 Exhaustive: all 256 (A,B) pairs with in_valid=1 -> Out equals the sign-extended integer product every cycle, and Out(A,B)==Out(B,A).
